// File: rtl/prog_ctrl.sv
// Program sequencer: launches one of three programs on a Start rising edge and times the run.
// Optional watchdog abort is compiled in with PROG_CTRL_WATCHDOG_EN.
module prog_ctrl #(
  parameter logic [9:0]  PROG0_BASE = 10'd0,
  parameter logic [9:0]  PROG1_BASE = 10'd128,
  parameter logic [9:0]  PROG2_BASE = 10'd256,
  parameter logic [15:0] WDOG_LIMIT = 16'd4095
) (
  input  logic        CLK,
  input  logic        Init,
  input  logic        Start,
  input  logic [1:0]  ProgSel,
  input  logic        Halt,
  output logic        FetchInit,
  output logic [9:0]  StartPC,
  output logic [1:0]  ProgState,
  output logic        Busy,
  output logic        Done,
  output logic        SelErr,
  output logic [15:0] CycleCount
`ifdef PROG_CTRL_WATCHDOG_EN
  , output logic      Timeout
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  state_e      state_q, state_d;
  logic        start_q, start_d;
  logic        armed_q, armed_d;
  logic [9:0]  pc_q, pc_d;
  logic [1:0]  prog_q, prog_d;
  logic [15:0] cnt_q, cnt_d;
  logic        selerr_q, selerr_d;
  logic        fetch_init_q, fetch_init_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        start_edge;
`ifdef PROG_CTRL_WATCHDOG_EN
  logic        timeout_q, timeout_d;
`endif

  // armed_q blocks a Start held high across reset release until it has been seen low
  assign start_edge = Start & ~start_q & armed_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    prog_d   = prog_q;
    cnt_d    = cnt_q;
    selerr_d = 1'b0;
    start_d  = Start;
    armed_d  = armed_q | ~Start;
`ifdef PROG_CTRL_WATCHDOG_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start_edge) begin
          if (ProgSel != 2'd3) begin
            state_d = LOAD;
            prog_d  = ProgSel;
            cnt_d   = 16'd0;
`ifdef PROG_CTRL_WATCHDOG_EN
            timeout_d = 1'b0;
`endif
            case (ProgSel)
              2'd0:    pc_d = PROG0_BASE;
              2'd1:    pc_d = PROG1_BASE;
              default: pc_d = PROG2_BASE;
            endcase
          end else begin
            selerr_d = 1'b1;
          end
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        if (Halt) begin
          state_d = DONE;
`ifdef PROG_CTRL_WATCHDOG_EN
        end else if (cnt_d >= WDOG_LIMIT) begin
          state_d   = DONE;
          timeout_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // Status outputs are registered from the next state so they line up with state_q
    fetch_init_d = (state_d != RUN);
    busy_d       = (state_d == LOAD) || (state_d == RUN);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge CLK) begin
    if (Init) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      armed_q      <= ~Start;
      pc_q         <= PROG0_BASE;
      prog_q       <= 2'd0;
      cnt_q        <= 16'd0;
      selerr_q     <= 1'b0;
      fetch_init_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef PROG_CTRL_WATCHDOG_EN
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      armed_q      <= armed_d;
      pc_q         <= pc_d;
      prog_q       <= prog_d;
      cnt_q        <= cnt_d;
      selerr_q     <= selerr_d;
      fetch_init_q <= fetch_init_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef PROG_CTRL_WATCHDOG_EN
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign FetchInit  = fetch_init_q;
  assign StartPC    = pc_q;
  assign ProgState  = prog_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign SelErr     = selerr_q;
  assign CycleCount = cnt_q;
`ifdef PROG_CTRL_WATCHDOG_EN
  assign Timeout    = timeout_q;
`endif

endmodule

// File: tb/tb_prog_ctrl.sv
// Scoreboard bench for prog_ctrl: a run-level reference model predicts every cycle's outputs.
module tb_prog_ctrl;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        Init, Start, Halt;
  logic [1:0]  ProgSel;
  logic        FetchInit, Busy, Done, SelErr;
  logic [9:0]  StartPC;
  logic [1:0]  ProgState;
  logic [15:0] CycleCount;
`ifdef PROG_CTRL_WATCHDOG_EN
  logic        Timeout;
  localparam int WD_LIMIT = 20;
`endif

  prog_ctrl #(.WDOG_LIMIT(16'd20)) dut (
    .CLK(CLK), .Init(Init), .Start(Start), .ProgSel(ProgSel), .Halt(Halt),
    .FetchInit(FetchInit), .StartPC(StartPC), .ProgState(ProgState),
    .Busy(Busy), .Done(Done), .SelErr(SelErr), .CycleCount(CycleCount)
`ifdef PROG_CTRL_WATCHDOG_EN
    , .Timeout(Timeout)
`endif
  );

  typedef struct {
    int fi; int pc; int ps; int busy; int done; int selerr; int cnt; int to;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int passed = 0;

  // Reference model: run phase as a plain integer, 0 idle, 1 loading, 2 running, 3 finished
  int m_phase, m_prev_start, m_may_fire, m_cnt, m_prog, m_pc, m_selerr, m_to;
  int bases[3] = '{0, 128, 256};

  task automatic model_clock(input int i, input int s, input int sel, input int h);
    if (i != 0) begin
      m_phase = 0; m_prog = 0; m_pc = bases[0]; m_cnt = 0;
      m_selerr = 0; m_to = 0; m_prev_start = 0; m_may_fire = (s == 0);
    end else begin
      int rise;
      rise = (s != 0 && m_prev_start == 0 && m_may_fire != 0);
      m_selerr = 0;
      if (m_phase == 0 || m_phase == 3) begin
        if (rise) begin
          if (sel == 3) m_selerr = 1;
          else begin
            m_phase = 1; m_prog = sel; m_pc = bases[sel]; m_cnt = 0; m_to = 0;
          end
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (h != 0) m_phase = 3;
`ifdef PROG_CTRL_WATCHDOG_EN
        else if (m_cnt >= WD_LIMIT) begin m_phase = 3; m_to = 1; end
`endif
      end
      if (s == 0) m_may_fire = 1;
      m_prev_start = s;
    end
  endtask

  task automatic step(input int i, input int s, input int sel, input int h);
    exp_t e;
    @(negedge CLK);
    Init = i[0]; Start = s[0]; ProgSel = sel[1:0]; Halt = h[0];
    model_clock(i, s, sel, h);
    e.fi = (m_phase != 2); e.pc = m_pc; e.ps = m_prog;
    e.busy = (m_phase == 1 || m_phase == 2); e.done = (m_phase == 3);
    e.selerr = m_selerr; e.cnt = m_cnt; e.to = m_to;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("FetchInit", int'(FetchInit), e.fi);
      chk("StartPC", int'(StartPC), e.pc);
      chk("ProgState", int'(ProgState), e.ps);
      chk("Busy", int'(Busy), e.busy);
      chk("Done", int'(Done), e.done);
      chk("SelErr", int'(SelErr), e.selerr);
      chk("CycleCount", int'(CycleCount), e.cnt);
`ifdef PROG_CTRL_WATCHDOG_EN
      chk("Timeout", int'(Timeout), e.to);
`endif
    end
  end

  initial begin
    Init = 1'b1; Start = 1'b0; ProgSel = 2'd0; Halt = 1'b0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // Program 1 launch, 10 counted cycles then Halt, Start toggling mid-run is ignored
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    for (int k = 0; k < 10; k++) step(0, k % 2, k % 4, 0);
    step(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1);
    // Relaunch from the finished state with program 2
    step(0, 1, 2, 0);
    step(0, 1, 2, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 0);
    // Init in the middle of a run
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // Invalid select from idle, then a held-high Start does not refire
    step(0, 1, 3, 0);
    step(0, 1, 3, 0);
    step(0, 0, 3, 0);
    step(0, 1, 3, 0);
    step(0, 0, 0, 0);
    // Start held high across reset release is not an edge
    step(1, 1, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int k = 0; k < 25; k++) step(0, 1, 0, 0);
    // Halt exactly when the count reaches 20
    step(0, 0, 0, 1);
    step(0, 1, 1, 0);
    for (int k = 0; k < 20; k++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    // Randomized traffic
    for (int k = 0; k < 3000; k++)
      step(($urandom_range(0, 80) == 0) ? 1 : 0, int'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0) ? 1 : 0);
    step(0, 0, 0, 0);
    @(negedge CLK);
    @(negedge CLK);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/prog_ctrl.md
PROG_CTRL -- requirements
Module: prog_ctrl

Interface
REQ-001 Parameter PROG0_BASE, default 10'd0, start PC of program 0.
REQ-002 Parameter PROG1_BASE, default 10'd128, start PC of program 1.
REQ-003 Parameter PROG2_BASE, default 10'd256, start PC of program 2.
REQ-004 Parameter WDOG_LIMIT, default 16'd4095, RUN-cycle limit before abort (WATCHDOG_EN only).
REQ-005 CLK  input  1  sole clock; all state changes on posedge CLK only.
REQ-006 Init  input  1  reset, synchronous, active-high.
REQ-007 Start  input  1  level request; a run is requested on a 0->1 transition.
REQ-008 ProgSel  input  2  program select, sampled with the Start rising edge.
REQ-009 Halt  input  1  done flag from fetch unit.
REQ-010 FetchInit  output  1  holds fetch unit in reset/hold while 1.
REQ-011 StartPC  output  10  base address loaded into fetch unit.
REQ-012 ProgState  output  2  latched program number of current/last run.
REQ-013 Busy  output  1  run in progress (LOAD or RUN).
REQ-014 Done  output  1  last run finished; high in DONE.
REQ-015 SelErr  output  1  one-cycle pulse on invalid ProgSel.
REQ-016 CycleCount  output  16  RUN cycles of current/last run.
REQ-017 Timeout  output  1  last run aborted by watchdog (present only with WATCHDOG_EN).

Function
REQ-018 FSM states IDLE, LOAD, RUN, DONE; all outputs registered.
REQ-019 Start edge detect: registered Start_q; edge = Start & ~Start_q; Start_q cleared by reset.
REQ-020 IDLE or DONE, edge, ProgSel in {0,1,2}: latch ProgState, StartPC = matching base, go LOAD.
REQ-021 IDLE or DONE, edge, ProgSel=3: SelErr=1 for one cycle, state, ProgState, StartPC unchanged.
REQ-022 LOAD lasts exactly one cycle: FetchInit=1, CycleCount cleared to 0, Done=0, Timeout=0, then RUN.
REQ-023 Latency: edge sampled at posedge N -> LOAD from N, RUN from N+1, FetchInit low from N+1.
REQ-024 RUN: FetchInit=0; CycleCount += 1 each cycle, saturating at 16'hFFFF.
REQ-025 RUN with Halt=1 at a posedge: go DONE; that cycle is counted.
REQ-026 Start edges during LOAD or RUN are ignored (no restart, no SelErr).
REQ-027 DONE: FetchInit=1, Done=1, Busy=0, CycleCount/ProgState/StartPC held until next accepted edge.
REQ-028 FetchInit=1 in IDLE, LOAD, DONE; Busy=1 exactly in LOAD and RUN.
REQ-029 Halt outside RUN is ignored.

Reset
REQ-030 Init=1 at posedge: state IDLE, FetchInit=1, StartPC=PROG0_BASE, ProgState=0, Busy=0, Done=0, SelErr=0, CycleCount=0, Timeout=0, Start_q=0.
REQ-031 Init overrides all other inputs, including mid-RUN; a Start held high across reset release is not an edge until it goes low then high.

Configuration
REQ-032 Macro PROG_CTRL_WATCHDOG_EN defined: in RUN, if Halt=0 and CycleCount reaches WDOG_LIMIT, go DONE with Timeout=1; Halt on the same cycle takes priority (Timeout=0).
REQ-033 Macro undefined: no Timeout port, no WDOG_LIMIT comparison; RUN ends only on Halt or Init.

Verification
REQ-034 Reset then Start 0->1, ProgSel=1 -> LOAD next cycle with StartPC=128, ProgState=1, FetchInit low one cycle later.
REQ-035 RUN, Halt asserted after 10 RUN cycles -> DONE, Done=1, CycleCount=11, FetchInit=1.
REQ-036 ProgSel=3 with Start edge in IDLE -> SelErr pulse 1 cycle, state IDLE, StartPC=0.
REQ-037 Start toggled during RUN -> no state change; Init pulse mid-RUN -> IDLE, all outputs at reset values next cycle.
REQ-038 WATCHDOG_EN, WDOG_LIMIT=16'd20, Halt never asserted -> DONE with Timeout=1, CycleCount=20; repeat with Halt on that cycle -> Timeout=0.
REQ-039 DONE then Start edge, ProgSel=2 -> LOAD, StartPC=256, CycleCount=0, Done=0.
